// File: rtl/popcount_frame_accum.sv
// popcount_frame_accum: streaming per-word ones counter with saturating per-frame accumulation.
//
// Optional feature macro: POPCOUNT_ONEHOT_EN (adds count_onehot, the one-hot decode of word_count).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   in_valid     input word present
//   in_ready     block can accept a word (ACCUM state and not in reset)
//   in_data      WIDTH-bit word to count
//   in_last      closes the frame with this word (sampled on accept only)
//   word_valid   one-cycle pulse the cycle after an accept
//   word_count   ones in the last accepted word, held until the next accept
//   count_onehot one-hot decode of word_count (POPCOUNT_ONEHOT_EN only)
//   frame_valid  frame result held until frame_ready
//   frame_ready  consumer takes the frame result
//   frame_sum    saturated total ones in the frame
//   frame_words  number of words in the frame
//   frame_sat    accumulator clamped at least once during the frame
module popcount_frame_accum #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 16,
    localparam int CW       = $clog2(WIDTH + 1),
    localparam int FW       = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             word_valid,
    output logic [CW-1:0]    word_count,
`ifdef POPCOUNT_ONEHOT_EN
    output logic [WIDTH:0]   count_onehot,
`endif
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [ACC_W-1:0] frame_sum,
    output logic [FW-1:0]    frame_words,
    output logic             frame_sat
);
    localparam logic ACCUM = 1'b0;
    localparam logic HOLD  = 1'b1;
    // Sum width wide enough that acc + popcount can never wrap before the clamp test.
    localparam int SW = ACC_W + CW;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic             state;
    logic [ACC_W-1:0] acc;
    logic [FW-1:0]    words;
    logic             sat;
    logic             accept;
    logic             close;
    logic             clamp;
    logic [CW-1:0]    ones;
    logic [SW-1:0]    sum;
    logic [ACC_W-1:0] acc_next;
    logic [FW-1:0]    words_next;

    assign in_ready = (state == ACCUM) && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++)
            ones = ones + CW'(in_data[i]);
    end

    assign sum        = SW'(acc) + SW'(ones);
    assign clamp      = sum > SW'(ACC_MAX);
    assign acc_next   = clamp ? ACC_MAX : sum[ACC_W-1:0];
    assign words_next = words + FW'(1);
    // in_last on the FRAME_LEN-th word still yields a single close.
    assign close      = accept && (in_last || words == FW'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACCUM;
            acc          <= '0;
            words        <= '0;
            sat          <= 1'b0;
            word_valid   <= 1'b0;
            word_count   <= '0;
`ifdef POPCOUNT_ONEHOT_EN
            count_onehot <= '0;
`endif
            frame_valid  <= 1'b0;
            frame_sum    <= '0;
            frame_words  <= '0;
            frame_sat    <= 1'b0;
        end else begin
            word_valid <= accept;
            if (accept) begin
                word_count   <= ones;
`ifdef POPCOUNT_ONEHOT_EN
                count_onehot <= (WIDTH + 1)'(1) << ones;
`endif
            end
            if (close) begin
                // Closing word is folded into the published totals; working state restarts.
                frame_valid <= 1'b1;
                frame_sum   <= acc_next;
                frame_words <= words_next;
                frame_sat   <= sat | clamp;
                acc         <= '0;
                words       <= '0;
                sat         <= 1'b0;
                state       <= HOLD;
            end else if (accept) begin
                acc   <= acc_next;
                words <= words_next;
                sat   <= sat | clamp;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
                state       <= ACCUM;
            end
        end
    end
endmodule

// File: doc/popcount_frame_accum.md
Name: popcount_frame_accum

Overview:
- Streaming population counter, parametrised successor of the 4-input ones-counter.
- Accepts WIDTH-bit words over a valid/ready handshake and returns a registered per-word ones count.
- Accumulates the counts over a frame of up to FRAME_LEN words, then presents the frame total on a second valid/ready handshake.
- Sits between a sample source and a downstream statistics consumer.

Parameters:
- WIDTH, 4: bits per input word; per-word count ranges 0..WIDTH.
- FRAME_LEN, 8: maximum words per frame, must be >= 1.
- ACC_W, 16: frame accumulator width; saturates at 2^ACC_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to count.
- in_last  input  1  closes the frame early with this word; sampled only on accept.
- word_valid  output  1  one-cycle pulse, word_count updated.
- word_count  output  CW  ones in the last accepted word; CW=$clog2(WIDTH+1).
- frame_valid  output  1  frame result held.
- frame_ready  input  1  consumer takes the frame result.
- frame_sum  output  ACC_W  total ones in the frame, saturated.
- frame_words  output  FW  words in the frame; FW=$clog2(FRAME_LEN+1).
- frame_sat  output  1  accumulator saturated during this frame.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset values: all outputs 0, word counter 0, accumulator 0, state ACCUM. in_ready is 0 while reset is high and 1 in the first cycle after.
- Accept: a word is accepted when in_valid && in_ready on a rising edge.
- in_ready: equals (state==ACCUM) && !reset. It does not depend combinationally on in_valid.
- Per-word count, latency 1:
  - The cycle after an accept, word_valid=1 and word_count = popcount(in_data).
  - word_count holds its value until the next accept.
  - word_valid is 0 in cycles that do not follow an accept.
- Accumulate:
  - acc_next = min(acc + popcount, 2^ACC_W-1).
  - On clamp, a sticky sat flag is set for the current frame.
  - The word counter increments on every accept.
- Frame close: a frame closes on an accepted word if in_last=1 or if this is word number FRAME_LEN. The closing word is included in the totals.
- State ACCUM:
  - Accepts words.
  - On a close, the next state is HOLD.
  - In the cycle after the close: frame_valid=1, frame_sum holds the final acc, frame_words holds the count, frame_sat holds sat.
  - The internal acc, word counter and sat are cleared on that same edge.
- State HOLD:
  - in_ready=0.
  - frame_sum, frame_words and frame_sat are stable while frame_valid=1.
  - When frame_valid && frame_ready on an edge, the block returns to ACCUM, frame_valid=0, and in_ready=1 in the following cycle.
  - Minimum gap between the closing word and the next accept is 2 cycles, even with frame_ready tied high.
- frame_ready while frame_valid=0 is ignored.
- in_data and in_last are ignored when no accept occurs.
- FRAME_LEN=1: every accepted word closes a frame.
- in_last with the counter already at FRAME_LEN-1: a single close, no double frame.
- Saturation:
  - frame_sum never wraps.
  - frame_sat=1 exactly when the true sum exceeds 2^ACC_W-1.
  - frame_words is still exact.
- Reset mid-frame or in HOLD:
  - The partial frame and any pending frame result are discarded.
  - frame_valid=0 on the next edge.
  - No word_valid pulse is generated for a word presented during reset.

Optional Feature:
- Macro: POPCOUNT_ONEHOT_EN.
- Defined:
  - Adds output port count_onehot [WIDTH:0].
  - count_onehot is the one-hot decode of word_count: bit k=1 iff the word had k ones.
  - It is registered with the same latency and hold rules as word_count.
  - Reset value is 0, all bits clear, not bit0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=4, FRAME_LEN=8, ACC_W=16 unless stated):
- Reset release, in_valid=1 continuously:
  - in_ready=0 during reset, 1 the first cycle after.
  - No word_valid until the cycle after the first accept.
- Words 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, then in_last=1 on 4'hA:
  - word_count sequence is 0,1,2,3,4,2, each 1 cycle after its accept.
  - Then frame_sum=12, frame_words=6, frame_sat=0.
  - With POPCOUNT_ONEHOT_EN, count_onehot sequence is 5'b00001, 00010, 00100, 01000, 10000, 00100.
- 8 words of 4'hF, no in_last, frame_ready=0 for 5 cycles:
  - frame_valid rises after word 8 with frame_sum=32, frame_words=8.
  - in_ready=0 and outputs are stable for the 5 cycles.
  - After the frame_ready handshake, in_ready=1 one cycle later.
- ACC_W=3, words 4'hF, 4'hF with in_last:
  - frame_sum=7, frame_sat=1, frame_words=2.
  - The next frame, 4'h1 with in_last, gives frame_sum=1, frame_sat=0.
- FRAME_LEN=1, frame_ready=1, in_valid=1 continuously:
  - Accepts occur every 2nd cycle, each giving frame_words=1.
- reset asserted for 1 cycle after 3 accepted words of 4'hF, then 2 words of 4'h1 with in_last:
  - frame_sum=2, frame_words=2.
